// File: rtl/filter_seq_pkg.sv
// rtl/filter_seq_pkg.sv - shared types and constants for the filter sequencing controller
package filter_seq_pkg;

  localparam int STATE_W      = 3;
  localparam int DEFAULT_TAPS = 3;
  localparam int OVR_CNT_W    = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLR   = 3'd2,
    MAC   = 3'd3,
    STORE = 3'd4
  } state_t;

endpackage

// File: rtl/filter_seq_ctrl_if.sv
// rtl/filter_seq_ctrl_if.sv - strobe/enable bundle between controller and filter datapath (OVERRUN_CNT_EN adds ovr_cnt)
interface filter_seq_ctrl_if #(
  parameter int IDX_W = 2
);
  import filter_seq_pkg::*;

  logic             start;
  logic             ovr_clr;
  logic             en_in;
  logic             en_shift;
  logic             acc_clr;
  logic             en_acc;
  logic [IDX_W-1:0] tap_idx;
  logic             en_out;
  logic             done;
  logic             busy;
  logic             overrun;
`ifdef OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt;
`endif

  modport master (
    input  start, ovr_clr,
`ifdef OVERRUN_CNT_EN
    output ovr_cnt,
`endif
    output en_in, en_shift, acc_clr, en_acc, tap_idx, en_out, done, busy, overrun
  );

  modport slave (
    output start, ovr_clr,
`ifdef OVERRUN_CNT_EN
    input  ovr_cnt,
`endif
    input  en_in, en_shift, acc_clr, en_acc, tap_idx, en_out, done, busy, overrun
  );

endinterface

// File: rtl/filter_seq_ctrl_tap_counter.sv
// rtl/filter_seq_ctrl_tap_counter.sv - tap index counter with clear, increment and terminal count
module tap_counter #(
  parameter int TAPS  = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] value,
  output logic             tc
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

  assign tc = (value == LAST);

endmodule

// File: rtl/filter_seq_ctrl.sv
// rtl/filter_seq_ctrl.sv - load/shift/clear/MAC/store enable sequencer (OVERRUN_CNT_EN adds dropped-start counter)
module filter_seq_ctrl
  import filter_seq_pkg::*;
#(
  parameter int TAPS  = DEFAULT_TAPS,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  filter_seq_ctrl_if.master bus
);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] tap_cnt;
  logic             tap_tc;
  logic             drop;
  logic             overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bus.en_in    = 1'b0;
    bus.en_shift = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.en_acc   = 1'b0;
    bus.en_out   = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nx = LOAD;
      end
      LOAD: begin
        bus.en_in    = 1'b1;
        bus.en_shift = 1'b1;
        state_nx     = CLR;
      end
      CLR: begin
        bus.acc_clr = 1'b1;
        state_nx    = MAC;
      end
      MAC: begin
        bus.en_acc = 1'b1;
        if (tap_tc) state_nx = STORE;
      end
      STORE: begin
        bus.en_out = 1'b1;
        bus.done   = 1'b1;
        state_nx   = bus.start ? LOAD : IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Counter is held at zero outside MAC and wraps to zero on the last tap.
  tap_counter #(
    .TAPS  (TAPS),
    .IDX_W (IDX_W)
  ) u_tap_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state != MAC) || tap_tc),
    .inc   (state == MAC),
    .value (tap_cnt),
    .tc    (tap_tc)
  );

  assign bus.tap_idx = tap_cnt;

  assign drop = bus.start && ((state == LOAD) || (state == CLR) || (state == MAC));

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;

`ifdef OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else if (drop) begin
      if (bus.ovr_clr) begin
        ovr_cnt_q <= OVR_CNT_W'(1);
      end else if (ovr_cnt_q != {OVR_CNT_W{1'b1}}) begin
        ovr_cnt_q <= ovr_cnt_q + 1'b1;
      end
    end else if (bus.ovr_clr) begin
      ovr_cnt_q <= '0;
    end
  end

  assign bus.ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: doc/filter_seq_ctrl.md
Name: filter_seq_ctrl

Overview:
Sequencing controller for the fixed-point filter datapath built from enable-gated n-bit registers (input, delay-line, accumulator and output registers). On each sample strobe it generates the one-cycle register enables in order: load, shift, accumulator clear, TAPS multiply-accumulate steps, and output store. It also drives the coefficient/tap index and flags dropped samples. It sits between the sample-rate strobe generator and the filter datapath.

Parameters:
TAPS, 3, number of MAC steps per sample; legal range 1..16.
IDX_W, 2, width of tap_idx; must satisfy 2^IDX_W >= TAPS.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  sample strobe; one-cycle pulse requesting one filter pass.
ovr_clr  in  1  clears the sticky overrun flag.
en_in  out  1  input-register enable.
en_shift  out  1  delay-line register enable.
acc_clr  out  1  accumulator synchronous clear.
en_acc  out  1  accumulator register enable.
tap_idx  out  IDX_W  coefficient/tap select during MAC.
en_out  out  1  output-register enable.
done  out  1  one-cycle pulse; pass complete.
busy  out  1  high in every state except IDLE.
overrun  out  1  sticky flag; a start was dropped.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, tap_idx 0, overrun 0, every enable 0, done 0, busy 0.
- rst asserted mid-pass aborts the pass at the next edge. No en_out or done is issued for the aborted pass.
- Moore outputs: every enable, done, busy and tap_idx are decoded from registered state and counter only. No combinational path from any input to any output.
- States and transitions:
  - IDLE: start=1 -> LOAD; otherwise stay.
  - LOAD (1 cycle): en_in=1, en_shift=1. Next state CLR.
  - CLR (1 cycle): acc_clr=1, tap_idx=0. Next state MAC.
  - MAC (TAPS cycles): en_acc=1. tap_idx steps 0,1,...,TAPS-1, one value per cycle. When tap_idx==TAPS-1 -> STORE. tap_idx never exceeds TAPS-1 and returns to 0 on exit.
  - STORE (1 cycle): en_out=1, done=1. start=1 -> LOAD (back-to-back, not an overrun); otherwise -> IDLE.
- Latency: start sampled high at edge k -> LOAD during cycle k+1 -> done during cycle k+3+TAPS. A pass occupies TAPS+3 cycles. Minimum start spacing without overrun is TAPS+3 cycles.
- tap_idx outside MAC is 0.
- Overrun:
  - start=1 in LOAD, CLR or MAC is ignored and sets overrun at the next edge.
  - ovr_clr=1 clears overrun.
  - Same-cycle overrun event and ovr_clr: set wins.
- TAPS=1: MAC lasts exactly one cycle with tap_idx=0.
- Mutual exclusion: at most one of en_in, acc_clr, en_acc, en_out is high in any cycle (en_in and en_shift always together).

Optional Feature:
OVERRUN_CNT_EN
- Defined: adds output port ovr_cnt (8 bits), which counts dropped starts.
  - Saturates at 255.
  - Cleared by rst or ovr_clr; same-cycle increment and ovr_clr gives 1.
  - Does not affect the overrun flag.
- Not defined: ovr_cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package filter_seq_pkg holds:
  - the state enumeration (IDLE, LOAD, CLR, MAC, STORE) and the state-width constant;
  - the default TAPS;
  - the ovr_cnt width constant (8).
- One sub-module, tap_counter: IDX_W-bit counter with synchronous clear, increment enable, and a terminal-count output (value == TAPS-1). It is instantiated once by the controller.

Test Plan:
- Reset then single start, TAPS=3: LOAD at k+1, CLR at k+2, en_acc at k+3..k+5 with tap_idx 0,1,2, en_out+done at k+6, busy low at k+7.
- start during STORE: next cycle is LOAD; no overrun; two done pulses exactly 6 cycles apart.
- start during MAC (tap_idx=1): pass completes unchanged; overrun=1 from the next cycle. ovr_clr pulse returns it to 0. Simultaneous new overrun and ovr_clr leaves it at 1.
- rst pulse during MAC (tap_idx=1): all outputs 0 and tap_idx 0 after the edge; no done. A fresh start then runs a full correct pass.
- TAPS=1 build: exactly one en_acc cycle with tap_idx=0; done at k+4.
- OVERRUN_CNT_EN build: 300 starts issued during MAC -> ovr_cnt=255 (saturated); ovr_clr -> 0.
